// File: rtl/multiport_reg_file.sv
// ============================================================================
// multiport_reg_file
//
// Parametrised multi-port register file for the DDR execute pipeline, plus a
// valid-tracked wide burst buffer.
//
// Register file
//   - NUM_REGS x DATA_W array. Entries 0/1/2 are also the stride registers
//     casr/basr/rasr. They are readable and writable through the normal ports.
//   - Write priority per address, lowest to highest: srf_wen, then write
//     port 0, 1, ..., N_WR-1. The highest active writer wins.
//   - Reads are combinational. With BYPASS=1 a read returns the winning
//     same-cycle write for its address when there is one.
//
// Burst buffer
//   - WIDE_WORDS words with per-word valid bits. wide_full is the registered
//     AND of the valid bits.
//   - wide_take while full clears every valid bit. A write in the same cycle
//     lands after the clear, so the next burst follows with no bubble.
//   - A write while full without take is dropped and pulses wide_overflow.
//   - Word data is only cleared by reset, never by take.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   rf_raddr / rf_rdata   N_RD read ports (port i at [AW*i +: AW])
//   rf_wen/waddr/wdata    N_WR write ports
//   srf_wen, srf_value    one-hot-ish stride update (bit0 casr..bit2 rasr)
//   casr, basr, rasr      stride register outputs (regs 0, 1, 2)
//   wide_wen/offset/wdata burst buffer word write
//   wide_take             consumer accepts a full burst
//   wide_valid/full/data  burst buffer state
//   wide_overflow         one-cycle pulse per dropped burst write
// ============================================================================
module multiport_reg_file #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int N_RD       = 8,
    parameter int N_WR       = 8,
    parameter int WIDE_WORDS = 16,
    parameter int BYPASS     = 1,
    // Derived widths; leave at their defaults.
    parameter int AW         = $clog2(NUM_REGS),
    parameter int OW         = $clog2(WIDE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_RD*AW-1:0]           rf_raddr,
    output logic [N_RD*DATA_W-1:0]       rf_rdata,
    input  logic [N_WR-1:0]              rf_wen,
    input  logic [N_WR*AW-1:0]           rf_waddr,
    input  logic [N_WR*DATA_W-1:0]       rf_wdata,
    input  logic [2:0]                   srf_wen,
    input  logic [DATA_W-1:0]            srf_value,
    output logic [DATA_W-1:0]            casr,
    output logic [DATA_W-1:0]            basr,
    output logic [DATA_W-1:0]            rasr,
    input  logic                         wide_wen,
    input  logic [OW-1:0]                wide_offset,
    input  logic [DATA_W-1:0]            wide_wdata,
    input  logic                         wide_take,
    output logic [WIDE_WORDS-1:0]        wide_valid,
    output logic                         wide_full,
    output logic [WIDE_WORDS*DATA_W-1:0] wide_data,
    output logic                         wide_overflow
);

    logic [DATA_W-1:0]     regs     [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_hit;
    logic [DATA_W-1:0]     wr_val   [NUM_REGS];

    logic [DATA_W-1:0]     wide_mem [WIDE_WORDS];
    logic [WIDE_WORDS-1:0] set_mask;
    logic [WIDE_WORDS-1:0] valid_next;
    logic                  take_ok;
    logic                  wen_ok;

    // Per-address write resolution. Writers are visited from lowest to
    // highest priority so a later match simply overrides an earlier one.
    always_comb begin
        for (int a = 0; a < NUM_REGS; a++) begin
            wr_hit[a] = 1'b0;
            wr_val[a] = '0;
        end
        for (int s = 0; s < 3; s++) begin
            if (srf_wen[s]) begin
                wr_hit[s] = 1'b1;
                wr_val[s] = srf_value;
            end
        end
        for (int p = 0; p < N_WR; p++) begin
            if (rf_wen[p]) begin
                wr_hit[rf_waddr[AW*p +: AW]] = 1'b1;
                wr_val[rf_waddr[AW*p +: AW]] = rf_wdata[DATA_W*p +: DATA_W];
            end
        end
    end

    // Read ports. Bypass is suppressed while in reset because no write can
    // be accepted then, so the reads must show the cleared array.
    always_comb begin
        rf_rdata = '0;
        for (int i = 0; i < N_RD; i++) begin
            if ((BYPASS != 0) && rst_n && wr_hit[rf_raddr[AW*i +: AW]]) begin
                rf_rdata[DATA_W*i +: DATA_W] = wr_val[rf_raddr[AW*i +: AW]];
            end else begin
                rf_rdata[DATA_W*i +: DATA_W] = regs[rf_raddr[AW*i +: AW]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                regs[a] <= '0;
            end
        end else begin
            for (int a = 0; a < NUM_REGS; a++) begin
                if (wr_hit[a]) begin
                    regs[a] <= wr_val[a];
                end
            end
        end
    end

    assign casr = regs[0];
    assign basr = regs[1];
    assign rasr = regs[2];

    // A take only counts when the buffer is full. A write is accepted when
    // the buffer is not full, or when it is being emptied in the same cycle.
    assign take_ok = wide_take & wide_full;
    assign wen_ok  = wide_wen & (~wide_full | wide_take);

    // Clear happens before set, so a write during a take starts the next
    // burst with exactly one valid word.
    always_comb begin
        set_mask = '0;
        if (wen_ok) begin
            set_mask[wide_offset] = 1'b1;
        end
        valid_next = (take_ok ? '0 : wide_valid) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wide_valid    <= '0;
            wide_full     <= 1'b0;
            wide_overflow <= 1'b0;
            for (int k = 0; k < WIDE_WORDS; k++) begin
                wide_mem[k] <= '0;
            end
        end else begin
            wide_valid    <= valid_next;
            wide_full     <= &valid_next;
            wide_overflow <= wide_wen & wide_full & ~wide_take;
            if (wen_ok) begin
                wide_mem[wide_offset] <= wide_wdata;
            end
        end
    end

    always_comb begin
        wide_data = '0;
        for (int k = 0; k < WIDE_WORDS; k++) begin
            wide_data[DATA_W*k +: DATA_W] = wide_mem[k];
        end
    end

endmodule

// File: doc/multiport_reg_file.md
# multiport_reg_file

Parametrised multi-port register file for the DDR execute pipeline. It generalises the fixed 8R/8W, 16×32 register file to configurable width, depth and port counts. New behaviour:
- architecturally mapped stride registers,
- deterministic write-port priority,
- optional same-cycle write-to-read bypass,
- a valid-tracked wide burst buffer with full/take handshake and overflow detection.

## Interface
Parameters:
- DATA_W, 32, width of every register and word
- NUM_REGS, 16, architectural registers (≥4, power of two); AW = clog2(NUM_REGS)
- N_RD, 8, read ports
- N_WR, 8, write ports
- WIDE_WORDS, 16, words in burst buffer (power of two); OW = clog2(WIDE_WORDS)
- BYPASS, 1, 1 = reads see same-cycle writes

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rf_raddr  in  N_RD*AW  read addresses, port i at [AW*i +: AW]
- rf_rdata  out  N_RD*DATA_W  read data, combinational
- rf_wen  in  N_WR  per-port write enable
- rf_waddr  in  N_WR*AW  write addresses
- rf_wdata  in  N_WR*DATA_W  write data
- srf_wen  in  3  one-hot stride update: bit0 casr, bit1 basr, bit2 rasr
- srf_value  in  DATA_W  stride update value
- casr, basr, rasr  out  DATA_W each  stride registers (= regs 0, 1, 2)
- wide_wen  in  1  write one word into burst buffer
- wide_offset  in  OW  word index
- wide_wdata  in  DATA_W  word data
- wide_take  in  1  consumer accepts full burst
- wide_valid  out  WIDE_WORDS  per-word valid
- wide_full  out  1  all words valid
- wide_data  out  WIDE_WORDS*DATA_W  burst contents, word k at [DATA_W*k +: DATA_W]
- wide_overflow  out  1  one-cycle pulse: a write was dropped

## Operation
- Single register array of NUM_REGS entries.
  - Addresses 0/1/2 are casr/basr/rasr, and are both readable and writable through the normal ports.
- Write resolution per address per cycle, lowest to highest priority: srf_wen, then write port 0, 1, …, N_WR-1. The highest-priority active writer wins; all others to that address are discarded.
- srf_wen with more than one bit set: each flagged stride register takes srf_value.
- Read port i:
  - BYPASS=0: registered value of reg[raddr].
  - BYPASS=1: the winning same-cycle write value for raddr if any writer is active, else the registered value.
- Burst buffer:
  - wide_wen with wide_full=0: word[offset] ← wdata and valid[offset] ← 1. Rewriting an already-valid word overwrites it.
  - wide_full = &wide_valid, registered and updated with valid.
  - wide_take with wide_full=1: next cycle all valid = 0.
  - Same-cycle take and wide_wen: clear first, then set the new word's valid, so the new burst starts with one word.
  - wide_take with wide_full=0: ignored.
  - wide_wen with wide_full=1 and no take: write dropped, wide_overflow = 1 next cycle.
- Word data is not cleared by take; only valid bits are cleared.

## Timing
- Reset (rst_n low, async): all registers including strides = 0, wide word data = 0, wide_valid = 0, wide_full = 0, wide_overflow = 0.
  - Reset mid-burst discards the partial burst.
  - State held while rst_n is low; first write is accepted on the first rising edge after deassertion.
- Register write latency: 1 cycle, visible on the next cycle's reads; 0 cycles if BYPASS=1.
- Stride outputs change 1 cycle after the write.
- wide_full rises the cycle after the last missing word is written. wide_data is stable while wide_full=1.
- Overflow pulse lasts exactly 1 cycle per dropped write.
- Back-to-back bursts are possible at 1 word/cycle; take on the full cycle plus a write the same cycle gives no bubble.

## Test plan
- Reset then read all addresses: all 0. srf_wen=3'b100, value 0x40: next cycle rasr=0x40 and a read of addr 2 returns 0x40.
- Ports 0, 3 and 7 all write addr 5 (0x11, 0x33, 0x77) in the same cycle: next cycle reg5 = 0x77. The same cycle with srf_wen=3'b001 and port 2 writing addr 0 = 0xAA: casr = 0xAA.
- BYPASS=1: write addr 9 = 0xDEAD and read addr 9 in the same cycle: rdata = 0xDEAD. BYPASS=0: old value that cycle, 0xDEAD the next.
- Write words 0..15 (value = 0x100+k) in scrambled order: wide_full=1 only after the 16th write, wide_data word 7 = 0x107. A write while full: wide_overflow pulses once and the data is unchanged.
- Full buffer, assert wide_take together with wide_wen offset 3: next cycle wide_full=0, wide_valid=16'h0008. wide_take while not full: no change.
- Assert rst_n low asynchronously mid-burst (between clock edges): outputs 0 immediately, wide_valid=0.
